// File: rtl/noc_params.sv
// Router-wide NoC parameters shared by the allocator and crossbar.
package noc_params;

   localparam int PORT_NUM = 5;
   localparam int SEL_W    = $clog2(PORT_NUM);

   typedef logic [SEL_W-1:0] port_idx_t;

endpackage

// File: rtl/switch_arbiter_pkg.sv
// Local types for the switch allocator.
package switch_arbiter_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } lock_t;

   localparam int PERF_W = 16;

endpackage

// File: rtl/switch_arbiter_rr_arbiter.sv
// Round-robin priority pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int N = 5,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         any
);

   always_comb begin
      int c;
      c   = 0;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 0; k < N; k++) begin
         c = (int'(ptr) + k) % N;
         if (!any && req[c]) begin
            any    = 1'b1;
            idx    = W'(c);
            gnt[c] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_arbiter.sv
// Per-output wormhole switch allocator with round-robin between packets.
// Optional SWITCH_ARB_PERF_EN adds per-output granted-flit counters.
module switch_arbiter #(
   parameter int PORT_NUM = noc_params::PORT_NUM,
   parameter int SEL_W    = $clog2(PORT_NUM)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [PORT_NUM-1:0]             req_i,
   input  logic [PORT_NUM-1:0][SEL_W-1:0]  req_port_i,
   input  logic [PORT_NUM-1:0]             req_head_i,
   input  logic [PORT_NUM-1:0]             req_tail_i,
   input  logic [PORT_NUM-1:0]             out_ready_i,
   output logic [PORT_NUM-1:0]             grant_o,
   output logic [PORT_NUM-1:0][SEL_W-1:0]  input_sel_o,
`ifdef SWITCH_ARB_PERF_EN
   output logic [PORT_NUM-1:0][15:0]       perf_grant_cnt_o,
`endif
   output logic [PORT_NUM-1:0]             out_valid_o
);

   import switch_arbiter_pkg::*;

   lock_t            lock_q  [PORT_NUM];
   lock_t            lock_d  [PORT_NUM];
   logic [SEL_W-1:0] owner_q [PORT_NUM];
   logic [SEL_W-1:0] owner_d [PORT_NUM];
   logic [SEL_W-1:0] ptr_q   [PORT_NUM];
   logic [SEL_W-1:0] ptr_d   [PORT_NUM];

   logic [PORT_NUM-1:0] elig    [PORT_NUM];
   logic [PORT_NUM-1:0] arb_gnt [PORT_NUM];
   logic [SEL_W-1:0]    arb_idx [PORT_NUM];
   logic                arb_any [PORT_NUM];
   logic [PORT_NUM-1:0] fire;

   function automatic logic [SEL_W-1:0] inc_idx(input logic [SEL_W-1:0] i);
      return (int'(i) == PORT_NUM - 1) ? '0 : i + SEL_W'(1);
   endfunction

   // A locked output only sees its owner, so the same picker serves both states.
   always_comb begin
      for (int o = 0; o < PORT_NUM; o++) begin
         for (int p = 0; p < PORT_NUM; p++) begin
            elig[o][p] = req_i[p] && (req_port_i[p] == SEL_W'(o)) &&
                         ((lock_q[o] == LOCKED) ? (owner_q[o] == SEL_W'(p))
                                                : req_head_i[p]);
         end
         fire[o] = rst && out_ready_i[o] && arb_any[o];
      end
   end

   for (genvar g = 0; g < PORT_NUM; g++) begin : g_arb
      rr_arbiter #(
         .N (PORT_NUM),
         .W (SEL_W)
      ) u_rr (
         .req (elig[g]),
         .ptr (ptr_q[g]),
         .gnt (arb_gnt[g]),
         .idx (arb_idx[g]),
         .any (arb_any[g])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int o = 0; o < PORT_NUM; o++) begin
            lock_q[o]  <= IDLE;
            owner_q[o] <= '0;
            ptr_q[o]   <= '0;
         end
      end else begin
         for (int o = 0; o < PORT_NUM; o++) begin
            lock_q[o]  <= lock_d[o];
            owner_q[o] <= owner_d[o];
            ptr_q[o]   <= ptr_d[o];
         end
      end
   end

   always_comb begin
      for (int o = 0; o < PORT_NUM; o++) begin
         lock_d[o]  = lock_q[o];
         owner_d[o] = owner_q[o];
         ptr_d[o]   = ptr_q[o];
         if (fire[o]) begin
            case (lock_q[o])
               IDLE: begin
                  if (req_tail_i[arb_idx[o]]) begin
                     ptr_d[o] = inc_idx(arb_idx[o]);
                  end else begin
                     lock_d[o]  = LOCKED;
                     owner_d[o] = arb_idx[o];
                  end
               end
               LOCKED: begin
                  if (req_tail_i[arb_idx[o]]) begin
                     lock_d[o] = IDLE;
                     ptr_d[o]  = inc_idx(owner_q[o]);
                  end
               end
               default: lock_d[o] = IDLE;
            endcase
         end
      end
   end

   always_comb begin
      grant_o = '0;
      for (int o = 0; o < PORT_NUM; o++) begin
         out_valid_o[o] = fire[o];
         input_sel_o[o] = fire[o] ? arb_idx[o] : '0;
         grant_o        = grant_o | (fire[o] ? arb_gnt[o] : '0);
      end
   end

`ifdef SWITCH_ARB_PERF_EN
   logic [PORT_NUM-1:0][PERF_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         for (int o = 0; o < PORT_NUM; o++) begin
            if (out_valid_o[o] && (cnt_q[o] != '1)) begin
               cnt_q[o] <= cnt_q[o] + PERF_W'(1);
            end
         end
      end
   end

   assign perf_grant_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_switch_arbiter.sv
// Directed plus randomized check of switch_arbiter against a packet-level model.
module tb_switch_arbiter;

   localparam int N = 5;
   localparam int SW = $clog2(N);

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N-1:0]         req, head, tail, ready;
   logic [N-1:0][SW-1:0] port;
   logic [N-1:0]         grant, oval;
   logic [N-1:0][SW-1:0] sel;
`ifdef SWITCH_ARB_PERF_EN
   logic [N-1:0][15:0]   perf;
`endif

   int errs = 0;
   int checks = 0;

   int m_lock [N];
   int m_own  [N];
   int m_ptr  [N];
   int m_cnt  [N];
   int e_win  [N];

   bit act   [N];
   bit first [N];
   int dst   [N];
   int rem   [N];

   always #5 clk = ~clk;

   switch_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req),
      .req_port_i  (port),
      .req_head_i  (head),
      .req_tail_i  (tail),
      .out_ready_i (ready),
      .grant_o     (grant),
      .input_sel_o (sel),
`ifdef SWITCH_ARB_PERF_EN
      .perf_grant_cnt_o (perf),
`endif
      .out_valid_o (oval)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clr();
      req = '0; head = '0; tail = '0; port = '0; ready = '1;
   endtask

   task automatic put(input int p, input int o, input bit h, input bit t);
      req[p] = 1'b1;
      port[p] = o[SW-1:0];
      head[p] = h;
      tail[p] = t;
   endtask

   // Expected outputs straight from the allocation rules.
   task automatic eval();
      logic [N-1:0] eg, ev;
      logic [N-1:0][SW-1:0] es;
      #1;
      eg = '0; ev = '0; es = '0;
      for (int o = 0; o < N; o++) begin
         e_win[o] = -1;
         if (rst && ready[o]) begin
            if (m_lock[o] != 0) begin
               if (req[m_own[o]] && port[m_own[o]] == o) e_win[o] = m_own[o];
            end else begin
               for (int k = 0; k < N; k++) begin
                  int p = (m_ptr[o] + k) % N;
                  if (e_win[o] < 0 && req[p] && head[p] && port[p] == o)
                     e_win[o] = p;
               end
            end
         end
         if (e_win[o] >= 0) begin
            eg[e_win[o]] = 1'b1;
            ev[o] = 1'b1;
            es[o] = SW'(e_win[o]);
         end
      end
      chk("grant", 32'(grant), 32'(eg));
      chk("valid", 32'(oval), 32'(ev));
      chk("sel", 32'(sel), 32'(es));
`ifdef SWITCH_ARB_PERF_EN
      for (int o = 0; o < N; o++) chk("perf", 32'(perf[o]), m_cnt[o]);
`endif
   endtask

   task automatic commit();
      @(posedge clk);
      for (int o = 0; o < N; o++) begin
         if (!rst) begin
            m_lock[o] = 0; m_own[o] = 0; m_ptr[o] = 0; m_cnt[o] = 0;
         end else if (e_win[o] >= 0) begin
            if (m_cnt[o] < 65535) m_cnt[o]++;
            if (m_lock[o] == 0) begin
               if (tail[e_win[o]]) m_ptr[o] = (e_win[o] + 1) % N;
               else begin m_lock[o] = 1; m_own[o] = e_win[o]; end
            end else if (tail[e_win[o]]) begin
               m_lock[o] = 0;
               m_ptr[o] = (m_own[o] + 1) % N;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic tick();
      eval();
      commit();
   endtask

   initial begin
      for (int o = 0; o < N; o++) begin
         m_lock[o] = 0; m_own[o] = 0; m_ptr[o] = 0; m_cnt[o] = 0; e_win[o] = -1;
         act[o] = 0; first[o] = 0; dst[o] = 0; rem[o] = 0;
      end
      rst = 1'b0;
      clr();
      put(0, 0, 1, 1);
      @(negedge clk);
      eval(); chk("rst_grant", 32'(grant), 0); commit();
      eval(); chk("rst_valid", 32'(oval), 0); commit();
      rst = 1'b1;
      clr();

      // single-flit contention on output 2
      put(1, 2, 1, 1); put(3, 2, 1, 1);
      eval(); chk("sf1_g", 32'(grant), 32'h02); chk("sf1_sel", 32'(sel[2]), 1);
      commit();
      req[1] = 1'b0;
      eval(); chk("sf2_g", 32'(grant), 32'h08); chk("sf2_sel", 32'(sel[2]), 3);
      commit();
      clr();

      // wormhole lock on output 4
      put(0, 4, 1, 0); put(2, 4, 1, 1);
      eval(); chk("wh_head", 32'(grant), 32'h01); commit();
      head[0] = 1'b0;
      eval(); chk("wh_body", 32'(grant), 32'h01); commit();
      tail[0] = 1'b1;
      eval(); chk("wh_tail", 32'(grant), 32'h01); commit();
      req[0] = 1'b0;
      eval(); chk("wh_next", 32'(grant), 32'h04); chk("wh_sel", 32'(sel[4]), 2);
      commit();
      clr();

      // backpressure on locked output 0
      put(1, 0, 1, 0);
      eval(); chk("bp_head", 32'(grant), 32'h02); commit();
      head[1] = 1'b0;
      ready[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         eval(); chk("bp_stall", 32'(grant), 0); commit();
      end
      ready[0] = 1'b1;
      eval(); chk("bp_body", 32'(grant), 32'h02); commit();
      tail[1] = 1'b1;
      eval(); chk("bp_tail", 32'(grant), 32'h02); commit();
      clr();

      // round-robin wrap on output 1
      put(3, 1, 1, 1);
      tick();
      clr();
      put(0, 1, 1, 1); put(4, 1, 1, 1);
      eval(); chk("wr_4", 32'(grant), 32'h10); chk("wr_sel4", 32'(sel[1]), 4);
      commit();
      req[4] = 1'b0;
      eval(); chk("wr_0", 32'(grant), 32'h01); chk("wr_sel0", 32'(sel[1]), 0);
      commit();
      clr();

      // reset while output 3 is locked
      put(2, 3, 1, 0);
      eval(); chk("rm_head", 32'(grant), 32'h04); commit();
      head[2] = 1'b0;
      rst = 1'b0;
      eval(); chk("rm_rst", 32'(grant), 0); commit();
      rst = 1'b1;
      eval(); chk("rm_body", 32'(grant), 0); chk("rm_val", 32'(oval), 0);
      commit();
      clr();

      // randomized well-formed packet traffic
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < N; p++) begin
            if (!act[p] && $urandom_range(0, 1) == 1) begin
               act[p] = 1; first[p] = 1;
               dst[p] = $urandom_range(0, N - 1);
               rem[p] = $urandom_range(1, 4);
            end
            req[p] = act[p];
            port[p] = act[p] ? SW'(dst[p]) : SW'($urandom_range(0, N - 1));
            head[p] = act[p] ? first[p] : 1'($urandom);
            tail[p] = act[p] ? (rem[p] == 1) : 1'($urandom);
            ready[p] = ($urandom_range(0, 3) != 0);
         end
         eval();
         commit();
         for (int o = 0; o < N; o++) begin
            if (e_win[o] >= 0) begin
               first[e_win[o]] = 0;
               rem[e_win[o]]--;
               if (rem[e_win[o]] == 0) act[e_win[o]] = 0;
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/switch_arbiter.md
Name: switch_arbiter

Overview:
- Output-side switch allocator for the router crossbar: picks, per output port, which input port drives it each cycle.
- Enforces wormhole packet locking, so an output stays owned by one input from head flit to tail flit.
- Uses per-output round-robin fairness between packets.
- Its select outputs drive the crossbar's per-output input-select bus directly.

Parameters:
- PORT_NUM, 5, number of router input ports and number of output ports.
- SEL_W, $clog2(PORT_NUM), width of a port index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- req_i  in  PORT_NUM  input p has a flit ready at its buffer head.
- req_port_i  in  PORT_NUM x SEL_W  destination output port of input p's flit.
- req_head_i  in  PORT_NUM  flit at input p is a head flit.
- req_tail_i  in  PORT_NUM  flit at input p is a tail flit; head and tail both set means a single-flit packet.
- out_ready_i  in  PORT_NUM  output o can accept a flit this cycle (downstream credit available).
- grant_o  out  PORT_NUM  input p's flit is transferred this cycle.
- input_sel_o  out  PORT_NUM x SEL_W  input index routed to output o (crossbar select).
- out_valid_o  out  PORT_NUM  output o carries a valid flit this cycle.

Behaviour:
- Grant and select outputs are combinational from the request inputs and the registered state; latency 0.
- The requester holds req_i stable until grant_o; a flit is consumed in the same cycle as its grant.
- Registered state per output o:
  - lock_q (IDLE/LOCKED)
  - owner_q (SEL_W bits)
  - rr_ptr_q (SEL_W bits)
- Eligibility at output o: input p is eligible when req_i[p] and req_port_i[p]==o, plus:
  - IDLE: req_head_i[p] is also set.
  - LOCKED: p==owner_q is also required.
- Body or tail flits aimed at an IDLE output are never granted.
- Selection: if out_ready_i[o]=0, there is no grant on o and the state holds. Otherwise:
  - IDLE: the first eligible input searching rr_ptr_q, rr_ptr_q+1, … modulo PORT_NUM (wrap from PORT_NUM-1 to 0).
  - LOCKED: owner_q, if eligible.
- An input requests exactly one output, so grant_o is at most one-hot per input.
- Transitions on a grant to winner w at output o:
  - IDLE, head with no tail: go to LOCKED and set owner_q=w; rr_ptr_q is unchanged.
  - IDLE, head with tail: stay IDLE and set rr_ptr_q=(w+1) mod PORT_NUM.
  - LOCKED, tail: go to IDLE and set rr_ptr_q=(owner_q+1) mod PORT_NUM.
  - LOCKED, non-tail: stay LOCKED.
- No grant at output o: all of that output's state holds.
- When out_valid_o[o]=0, input_sel_o[o]=0.
- Reset (rst=0 at a clock edge):
  - All outputs to IDLE, owner_q=0, rr_ptr_q=0.
  - Grants are suppressed while rst=0.
  - A reset mid-packet silently drops the lock.

Optional Feature:
- Macro: SWITCH_ARB_PERF_EN.
- Defined:
  - Adds output perf_grant_cnt_o (PORT_NUM x 16): per-output count of granted flits.
  - Increments on out_valid_o[o], saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and counters are absent; no other behaviour changes.

Decomposition:
- Shared package noc_params holds PORT_NUM and port_idx_t (logic [SEL_W-1:0]).
- Local package constants: an enum for lock state (IDLE, LOCKED).
- One natural sub-module, rr_arbiter: a PORT_NUM-wide round-robin priority pick given a request vector and a pointer.
  - Returns a one-hot grant and an index.
  - switch_arbiter instantiates it once per output.

Test Plan:
- Single-flit contention:
  - Cycle 0: inputs 1 and 3 each send a head+tail flit to output 2, out_ready=all 1, pointer at 0 → grant input 1, input_sel_o[2]=1.
  - Next cycle: grant input 3, since rr_ptr becomes 2.
- Wormhole lock:
  - Input 0 sends a 3-flit packet to output 4 while input 2 requests output 4 → input 2 gets no grant until input 0's tail is granted.
  - Input 2 is granted the cycle after the tail.
- Backpressure: input 1 is locked on output 0 and out_ready_i[0]=0 for 3 cycles → no grant and state holds; the body flit is granted when ready returns.
- Wrap-around: rr_ptr=4 with inputs 0 and 4 requesting output 1 → input 4 wins, the pointer wraps to 0, then input 0 wins.
- Reset mid-packet:
  - Assert rst=0 while output 3 is LOCKED → the following cycle has no grants.
  - After release, output 3 is IDLE and a body flit to it is refused.
- Perf counter (SWITCH_ARB_PERF_EN defined): counter preloaded at 16'hFFFE plus 3 grants on output 0 → perf_grant_cnt_o[0] reads 16'hFFFF.
